qed_dup_buffer: RTL and testbench
=================================

Name: qed_dup_buffer

Overview:
- Sits directly downstream of the per-cycle instruction constraint stage and feeds the core fetch port.
- In ORIG mode, passes constrained original instructions (registers x0–x15, memory half 0) to the core and records each one in a FIFO.
- On exec_dup, replays the recorded instructions as QED duplicates: register fields +16, memory offset into half 1.
- Asserts qed_check_ready once every original has been duplicated, so the formal checker can compare register/memory halves.

Parameters:
DEPTH, 8, FIFO entries (power of two, ≥2)
ADDR_W, 3, log2(DEPTH)
NOP_INSN, 32'h0000007F, encoding issued when nothing valid is sent (opcode 7'b1111111)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ifu_qed_instruction  input  32  constrained instruction from the constraint stage
exec_dup  input  1  symbolic request to begin duplicate replay
stall_IF  input  1  core fetch stall; freezes the block
qed_ifu_instruction  output  32  registered instruction to core
qed_vld_out  output  1  qed_ifu_instruction is a real (non-NOP) instruction
qed_check_ready  output  1  original and duplicate counts equal and nonzero
fifo_full  output  1  FIFO holds DEPTH entries
num_orig  output  ADDR_W+1  originals issued since last ORIG entry
num_dup  output  ADDR_W+1  duplicates issued since last ORIG entry

Behaviour:
- Reset (async, rst_n=0):
  - qed_ifu_instruction=NOP_INSN; qed_vld_out=0; qed_check_ready=0.
  - FIFO pointers and both counters =0; fifo_full=0; state=ORIG.
  - Reset mid-replay discards all FIFO contents.
- Outputs are registered; one-cycle latency from input sample to qed_ifu_instruction.
- stall_IF=1: no state, pointer, counter or output change; exec_dup and input are ignored that cycle.
- Opcode 7'b1111111 on input is a NOP: never pushed, never counted.
- State ORIG, evaluated in priority order:
  - exec_dup=1 and num_orig≠0 → DUP next cycle. Output NOP, vld=0. The coincident input instruction is dropped (exec_dup wins).
  - exec_dup=1 and num_orig=0 → remain ORIG, output NOP.
  - Valid input and FIFO not full → push; output the input unchanged; vld=1; num_orig+1.
  - Valid input and FIFO full → not pushed; output NOP; vld=0.
- State DUP:
  - Each cycle pop one entry, output its transform, vld=1, num_dup+1. Input is ignored.
  - When the pop empties the FIFO → CHECK next cycle.
- State CHECK:
  - Output NOP, vld=0.
  - qed_check_ready=1 (num_orig==num_dup≠0), registered, held while in CHECK.
  - exec_dup=0 → ORIG next cycle; counters and pointers cleared on that transition.
- Transform (per opcode of the popped entry):
  - 0010011 (I-ALU): set rd[4], rs1[4].
  - 0110011 (R-ALU): set rd[4], rs1[4], rs2[4].
  - 0000011 (LW): set rd[4]; set bit30 (address +1024; originals have [31:30]=00).
  - 0100011 (SW): set rs2[4]; set bit30.
  - Any other opcode: passed unchanged.
  - rd=x0 is still remapped (x0→x16); this is the intended QED register split.
- Counters never exceed DEPTH; no wrap. Pointers wrap modulo DEPTH. Full = count==DEPTH.

Decomposition:
- Shared package qed_pkg holds:
  - opcode constants: OP_IMM=7'b0010011, OP_REG=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_NOP=7'b1111111
  - NOP_INSN
  - state enum {ORIG, DUP, CHECK}
  - function qed_dup_transform(insn)
- One natural sub-module: qed_fifo, a DEPTH×32 synchronous FIFO with push/pop/full/empty/count, async active-low reset.

Test Plan:
- Reset then ADDI x1,x2,5 (32'h00510093), stall_IF=0 → next cycle out=32'h00510093, vld=1, num_orig=1.
- Push ADDI x1,x2,5, then exec_dup=1 → NOP cycle; next out=32'h00590893 (x17,x18), num_dup=1; then qed_check_ready=1.
- LW x3,0(x0)=32'h00002183 and SW x3,0(x0)=32'h00302023, then exec_dup → duplicates 32'h40002983, 32'h41302023; check_ready after both.
- Push 9 ADDIs with DEPTH=8 → fifo_full=1 after 8; 9th output NOP, vld=0, num_orig=8.
- During DUP, stall_IF=1 for 3 cycles → output, num_dup and FIFO frozen; replay resumes exactly after the stall.
- rst_n low mid-DUP with 4 entries → immediate NOP out, counters 0, ORIG; exec_dup=1 then stays in ORIG (num_orig=0).

Source files
------------

// File: rtl/qed_pkg.sv
// qed_pkg: opcodes, NOP encoding, FSM states and the QED duplicate transform
package qed_pkg;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'b1111111;
  localparam logic [31:0] NOP_INSN = 32'h0000007F;

  typedef enum logic [1:0] {ORIG, DUP, CHECK} state_t;

  // Bit 11 = rd[4], bit 19 = rs1[4], bit 24 = rs2[4], bit 30 moves memory into half 1.
  function automatic logic [31:0] qed_dup_transform(input logic [31:0] insn);
    logic [31:0] r;
    case (insn[6:0])
      OP_IMM:   r = insn | 32'h0008_0800;
      OP_REG:   r = insn | 32'h0108_0800;
      OP_LOAD:  r = insn | 32'h4000_0800;
      OP_STORE: r = insn | 32'h4100_0000;
      default:  r = insn;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/qed_fifo.sv
// qed_fifo: DEPTH x 32 synchronous FIFO with occupancy count and pointer clear
module qed_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = count == (ADDR_W+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{(ADDR_W-1){1'b0}}, do_push};
      rd_ptr <= rd_ptr + {{(ADDR_W-1){1'b0}}, do_pop};
      count  <= count + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
    end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/qed_dup_buffer.sv
// qed_dup_buffer: issues constrained originals, records them, then replays them as QED duplicates
module qed_dup_buffer
  import qed_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ifu_qed_instruction,
  input  logic            exec_dup,
  input  logic            stall_IF,
  output logic [31:0]     qed_ifu_instruction,
  output logic            qed_vld_out,
  output logic            qed_check_ready,
  output logic            fifo_full,
  output logic [ADDR_W:0] num_orig,
  output logic [ADDR_W:0] num_dup
);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t          state, state_n;
  logic [31:0]     insn_n, fifo_dout;
  logic            vld_n, push, pop, clr, fifo_empty, in_valid;
  logic [ADDR_W:0] orig_n, dup_n, fifo_count;

  assign in_valid = ifu_qed_instruction[6:0] != OP_NOP;

  qed_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr),
    .din(ifu_qed_instruction), .dout(fifo_dout),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );

  // Under stall the strobes stay low and the register bank below holds.
  always_comb begin
    state_n = state;
    insn_n  = NOP_INSN;
    vld_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    orig_n  = num_orig;
    dup_n   = num_dup;
    if (!stall_IF)
      case (state)
        ORIG:
          if (exec_dup) state_n = num_orig != '0 ? DUP : ORIG;
          else if (in_valid && !fifo_full) begin
            push   = 1'b1;
            insn_n = ifu_qed_instruction;
            vld_n  = 1'b1;
            orig_n = num_orig + ONE;
          end
        DUP: begin
          pop     = !fifo_empty;
          insn_n  = qed_dup_transform(fifo_dout);
          vld_n   = 1'b1;
          dup_n   = num_dup + ONE;
          state_n = fifo_count == ONE ? CHECK : DUP;
        end
        default:
          if (!exec_dup) begin
            state_n = ORIG;
            clr     = 1'b1;
            orig_n  = '0;
            dup_n   = '0;
          end
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state               <= ORIG;
      qed_ifu_instruction <= NOP_INSN;
      qed_vld_out         <= 1'b0;
      qed_check_ready     <= 1'b0;
      num_orig            <= '0;
      num_dup             <= '0;
    end else if (!stall_IF) begin
      state               <= state_n;
      qed_ifu_instruction <= insn_n;
      qed_vld_out         <= vld_n;
      qed_check_ready     <= state_n == CHECK;
      num_orig            <= orig_n;
      num_dup             <= dup_n;
    end
endmodule

// File: tb/tb_qed_dup_buffer.sv
// tb_qed_dup_buffer: directed checks of original issue, duplicate replay, stall and reset
module tb_qed_dup_buffer;
  localparam logic [31:0] NOP   = 32'h0000007F;
  localparam logic [31:0] ADDI  = 32'h00510093;
  localparam logic [31:0] ADDID = 32'h00590893;
  localparam logic [31:0] LW    = 32'h00002183;
  localparam logic [31:0] LWD   = 32'h40002983;
  localparam logic [31:0] SW    = 32'h00302023;
  localparam logic [31:0] SWD   = 32'h41302023;
  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] ADDD  = 32'h013908B3;
  localparam logic [31:0] LUI   = 32'h123452B7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ifu = NOP;
  logic        exec_dup = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] insn;
  logic        vld, ready, full;
  logic [3:0]  n_orig, n_dup;
  int          checks = 0;
  int          errors = 0;

  qed_dup_buffer dut (
    .clk(clk), .rst_n(rst_n), .ifu_qed_instruction(ifu), .exec_dup(exec_dup),
    .stall_IF(stall), .qed_ifu_instruction(insn), .qed_vld_out(vld),
    .qed_check_ready(ready), .fifo_full(full), .num_orig(n_orig), .num_dup(n_dup)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ei, input logic ev,
                         input logic er, input logic [3:0] eo, input logic [3:0] ed);
    chk({tag, ".insn"}, insn, ei);
    chk({tag, ".vld"}, {31'b0, vld}, {31'b0, ev});
    chk({tag, ".ready"}, {31'b0, ready}, {31'b0, er});
    chk({tag, ".num_orig"}, {28'b0, n_orig}, {28'b0, eo});
    chk({tag, ".num_dup"}, {28'b0, n_dup}, {28'b0, ed});
  endtask

  initial begin
    step();
    step();
    chk_out("reset", NOP, 0, 0, 0, 0);
    chk("reset.full", {31'b0, full}, 32'd0);
    rst_n = 1'b1;
    ifu = ADDI;
    step();
    chk_out("orig_addi", ADDI, 1, 0, 1, 0);
    ifu = NOP;
    step();
    chk_out("nop_input", NOP, 0, 0, 1, 0);
    exec_dup = 1'b1;
    step();
    chk_out("exec_nop", NOP, 0, 0, 1, 0);
    exec_dup = 1'b0;
    step();
    chk_out("dup_addi", ADDID, 1, 1, 1, 1);
    exec_dup = 1'b1;
    step();
    chk_out("check_hold", NOP, 0, 1, 1, 1);
    exec_dup = 1'b0;
    step();
    chk_out("check_exit", NOP, 0, 0, 0, 0);

    ifu = LW;  step(); chk_out("orig_lw", LW, 1, 0, 1, 0);
    ifu = SW;  step(); chk_out("orig_sw", SW, 1, 0, 2, 0);
    ifu = ADD; step(); chk_out("orig_add", ADD, 1, 0, 3, 0);
    ifu = LUI; step(); chk_out("orig_lui", LUI, 1, 0, 4, 0);
    ifu = ADDI;
    exec_dup = 1'b1;
    step();
    chk_out("exec_drops_input", NOP, 0, 0, 4, 0);
    exec_dup = 1'b0;
    step(); chk_out("dup_lw", LWD, 1, 0, 4, 1);
    step(); chk_out("dup_sw", SWD, 1, 0, 4, 2);
    step(); chk_out("dup_add", ADDD, 1, 0, 4, 3);
    step(); chk_out("dup_lui", LUI, 1, 1, 4, 4);
    ifu = NOP;
    step();
    chk_out("back_to_orig", NOP, 0, 0, 0, 0);

    ifu = ADDI;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("fill.num_orig", {28'b0, n_orig}, i);
    end
    chk("fill.full", {31'b0, full}, 32'd1);
    step();
    chk_out("overflow", NOP, 0, 0, 8, 0);
    ifu = NOP;
    exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    step();
    chk_out("replay1", ADDID, 1, 0, 8, 1);
    stall = 1'b1;
    exec_dup = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", ADDID, 1, 0, 8, 1);
      chk("stall.full", {31'b0, full}, 32'd0);
    end
    stall = 1'b0;
    exec_dup = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      step();
      chk_out("replay", ADDID, 1, i == 8, 8, 4'(i));
    end
    step();
    chk_out("replay_done", NOP, 0, 0, 0, 0);

    ifu = ADDI;
    for (int i = 0; i < 4; i++) step();
    ifu = NOP;
    exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    step();
    chk_out("pre_reset_dup", ADDID, 1, 0, 4, 1);
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", NOP, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    exec_dup = 1'b1;
    step();
    chk_out("exec_empty", NOP, 0, 0, 0, 0);
    step();
    chk_out("exec_empty2", NOP, 0, 0, 0, 0);
    exec_dup = 1'b0;
    ifu = LW;
    step();
    chk_out("post_reset_push", LW, 1, 0, 1, 0);
    ifu = NOP;
    exec_dup = 1'b1;
    step();
    exec_dup = 1'b0;
    step();
    chk_out("post_reset_dup", LWD, 1, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
